// File: rtl/dog_sprite_addr_gen.sv
// Dog sprite ROM address generator: hit test and pixel address from the scan position,
// animation frame sequencing on frame_tick, and a dog_on flag aligned to the ROM output.
module dog_sprite_addr_gen #(
  parameter int unsigned SPR_W     = 110,
  parameter int unsigned SPR_H     = 86,
  parameter int unsigned FRAME_DIV = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  dog_x,
  input  logic [9:0]  dog_y,
  input  logic        mode,
  input  logic        face_left,
  input  logic        anim_en,
  output logic [4:0]  frame,
  output logic [13:0] address,
  output logic        dog_on
);

  typedef enum logic [0:0] {StWalk, StSniff} anim_state_e;

  localparam logic [10:0] SprW11  = 11'(SPR_W);
  localparam logic [10:0] SprH11  = 11'(SPR_H);
  localparam logic [13:0] SprW14  = 14'(SPR_W);
  localparam logic [7:0]  DivLast = 8'(FRAME_DIV - 1);

  // Hit test in 11 bits so dog_x + SPR_W never wraps back onto column 0
  logic [10:0] x_ext, y_ext, dx_ext, dy_ext;
  logic [10:0] x_off, y_off, col_c;
  logic        hit;
  logic [13:0] addr_c;

  always_comb begin
    x_ext  = {1'b0, draw_x};
    y_ext  = {1'b0, draw_y};
    dx_ext = {1'b0, dog_x};
    dy_ext = {1'b0, dog_y};
    x_off  = x_ext - dx_ext;
    y_off  = y_ext - dy_ext;
    hit    = (x_ext >= dx_ext) && (x_ext < dx_ext + SprW11) &&
             (y_ext >= dy_ext) && (y_ext < dy_ext + SprH11);
    col_c  = face_left ? (SprW11 - 11'd1 - x_off) : x_off;
    addr_c = hit ? (14'(y_off) * SprW14 + 14'(col_c)) : 14'd0;
  end

  logic [13:0] address_q;
  logic        hit_q, dog_on_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address_q <= '0;
      hit_q     <= 1'b0;
      dog_on_q  <= 1'b0;
    end else begin
      address_q <= addr_c;
      hit_q     <= hit;
      dog_on_q  <= hit_q;
    end
  end

  // Animation sequencer; everything moves only on frame_tick
  anim_state_e state_q, state_d, mode_state;
  logic [4:0]  frame_q, frame_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWalk;
      frame_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    mode_state = mode ? StSniff : StWalk;
    if (frame_tick) begin
      if (mode_state != state_q) begin
        state_d = mode_state;
        cnt_d   = '0;
        frame_d = mode ? 5'd4 : 5'd0;
      end else if (anim_en) begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          unique case (state_q)
            StWalk:  frame_d = (frame_q == 5'd3) ? 5'd0 : frame_q + 5'd1;
            StSniff: frame_d = (frame_q == 5'd4) ? 5'd5 : 5'd4;
            default: frame_d = 5'd0;
          endcase
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  assign frame   = frame_q;
  assign address = address_q;
  assign dog_on  = dog_on_q;

endmodule

// File: tb/tb_dog_sprite_addr_gen.sv
// Directed bench for dog_sprite_addr_gen: address/dog_on pipeline, mirroring, edge clipping,
// animation sequencing with FRAME_DIV=2, and asynchronous reset.
module tb_dog_sprite_addr_gen;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic [9:0]  draw_x, draw_y, dog_x, dog_y;
  logic        mode, face_left, anim_en;
  logic [4:0]  frame;
  logic [13:0] address;
  logic        dog_on;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  dog_sprite_addr_gen #(
    .SPR_W     (110),
    .SPR_H     (86),
    .FRAME_DIV (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .dog_x      (dog_x),
    .dog_y      (dog_y),
    .mode       (mode),
    .face_left  (face_left),
    .anim_en    (anim_en),
    .frame      (frame),
    .address    (address),
    .dog_on     (dog_on)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive a scan position, check address one cycle later and dog_on two cycles later.
  task automatic scan_check(input int x, input int y, input int exp_addr, input bit exp_on);
    draw_x = 10'(x);
    draw_y = 10'(y);
    @(posedge clock); #1;
    check_eq($sformatf("address(%0d,%0d)", x, y), 32'(address), 32'(exp_addr));
    @(posedge clock); #1;
    check_eq($sformatf("dog_on(%0d,%0d)", x, y), 32'(dog_on), 32'(exp_on));
  endtask

  task automatic tick_check(input int exp_frame, input string tag);
    frame_tick = 1'b1;
    @(posedge clock); #1;
    frame_tick = 1'b0;
    check_eq(tag, 32'(frame), 32'(exp_frame));
    repeat (3) @(posedge clock);
    #1;
    check_eq({tag, "_hold"}, 32'(frame), 32'(exp_frame));
  endtask

  int walk_seq [10] = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
  int sniff_seq [4] = '{4, 5, 5, 4};

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    draw_x     = '0;
    draw_y     = '0;
    dog_x      = 10'd100;
    dog_y      = 10'd50;
    mode       = 1'b0;
    face_left  = 1'b0;
    anim_en    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_frame", 32'(frame), 0);
    check_eq("rst_address", 32'(address), 0);
    check_eq("rst_dog_on", 32'(dog_on), 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Corners and row step
    scan_check(100, 50, 0, 1'b1);
    scan_check(209, 50, 109, 1'b1);
    scan_check(100, 51, 110, 1'b1);
    scan_check(209, 135, 9459, 1'b1);
    // Just outside
    scan_check(99, 50, 0, 1'b0);
    scan_check(210, 50, 0, 1'b0);
    scan_check(100, 136, 0, 1'b0);
    // Mirrored
    face_left = 1'b1;
    scan_check(100, 50, 109, 1'b1);
    scan_check(209, 50, 0, 1'b1);
    face_left = 1'b0;

    // Right-edge clipping, no wrap to column 0
    dog_x = 10'd600;
    for (int x = 600; x < 640; x++) scan_check(x, 50, x - 600, 1'b1);
    for (int x = 0; x < 10; x++) scan_check(x, 50, 0, 1'b0);

    // Walk animation
    for (int i = 0; i < 10; i++) tick_check(walk_seq[i], $sformatf("walk_tick%0d", i));
    tick_check(1, "walk_tick10");
    tick_check(2, "walk_tick11");

    // anim_en low holds frame
    anim_en = 1'b0;
    tick_check(2, "anim_off_tick");
    tick_check(2, "anim_off_tick2");
    anim_en = 1'b1;

    // Mode change mid-frame waits for the tick
    mode = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check_eq("mode_between_ticks", 32'(frame), 2);
    tick_check(4, "mode_change_tick");
    for (int i = 0; i < 4; i++) tick_check(sniff_seq[i], $sformatf("sniff_tick%0d", i));

    // Async reset while a hit is showing
    dog_x = 10'd100;
    scan_check(150, 60, 10 * 110 + 50, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_frame", 32'(frame), 0);
    check_eq("async_rst_dog_on", 32'(dog_on), 0);
    check_eq("async_rst_address", 32'(address), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_eq("post_rst_dog_on_c1", 32'(dog_on), 0);
    check_eq("post_rst_address_c1", 32'(address), 1150);
    @(posedge clock); #1;
    check_eq("post_rst_dog_on_c2", 32'(dog_on), 1);
    check_eq("post_rst_frame", 32'(frame), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
